// File: rtl/swervolf_board_io_if.sv
// UART TX mux bundle between the candidate TX sources and the board I/O block.
// The master side drives the source lines and the requested select.
interface swervolf_board_io_if #(
    parameter int UART_CH = 2,
    parameter int SEL_W   = $clog2(UART_CH)
) ();
    logic [UART_CH-1:0] i_uart_tx;
    logic [SEL_W-1:0]   i_uart_sel;
    logic [SEL_W-1:0]   o_uart_sel;
    logic               o_uart_tx;

    modport master (output i_uart_tx, output i_uart_sel, input o_uart_sel, input o_uart_tx);
    modport slave  (input i_uart_tx, input i_uart_sel, output o_uart_sel, output o_uart_tx);
endinterface

// File: rtl/swervolf_board_io.sv
// Board I/O conditioning: switch sync/debounce/edge IRQ, LED blink, and an
// idle-gated UART TX source mux.
module swervolf_board_io #(
    parameter int SW_W            = 16,
    parameter int LED_W           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_DIV       = 12500000,
    parameter int UART_CH         = 2,
    parameter int UART_IDLE       = 16,
    localparam int SEL_W          = $clog2(UART_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [SW_W-1:0]   i_sw,
    output logic [SW_W-1:0]   o_sw,
    output logic [SW_W-1:0]   o_sw_rise,
    output logic [SW_W-1:0]   o_sw_fall,
    input  logic [SW_W-1:0]   i_irq_en,
    input  logic              i_irq_clr,
    output logic              o_irq,
    input  logic [LED_W-1:0]  i_led,
    input  logic [LED_W-1:0]  i_led_blink,
    output logic [LED_W-1:0]  o_led,
    swervolf_board_io_if.slave uart
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int ID_W = $clog2(UART_IDLE + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_DIV - 1);
    localparam logic [ID_W-1:0]  ID_LAST = ID_W'(UART_IDLE - 1);
    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(UART_CH);

    logic [SYNC_STAGES-1:0][SW_W-1:0] sync_q, sync_d;
    logic [SW_W-1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [SW_W-1:0]                  sw_q, sw_d, rise_q, rise_d, fall_q, fall_d;
    logic                             irq_q, irq_d;
    logic [BL_W-1:0]                  blink_cnt_q, blink_cnt_d;
    logic                             phase_q, phase_d;
    logic [LED_W-1:0]                 led_q, led_d;
    logic [SEL_W-1:0]                 sel_q, sel_d;
    logic [ID_W-1:0]                  idle_q, idle_d;
    logic                             tx_q, tx_d;
    logic [SW_W-1:0]                  s;
    logic                             line, pending;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], i_sw};
        sw_d     = sw_q;
        rise_d   = '0;
        fall_d   = '0;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < SW_W; i++) begin
            if (s[i] == sw_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                sw_d[i]     = s[i];
                rise_d[i]   = s[i];
                fall_d[i]   = ~s[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end

        // A new edge wins over a simultaneous clear.
        irq_d = (|((rise_q | fall_q) & i_irq_en)) | (irq_q & ~i_irq_clr);

        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
        if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        led_d = i_led & (~i_led_blink | {LED_W{phase_q}});

        // Only hand over once the active line has idled high long enough.
        line    = uart.i_uart_tx[sel_q];
        pending = (uart.i_uart_sel != sel_q) && ({1'b0, uart.i_uart_sel} < CH_LIM);
        tx_d    = line;
        sel_d   = sel_q;
        idle_d  = '0;
        if (pending && line) begin
            if (idle_q == ID_LAST) begin
                sel_d = uart.i_uart_sel;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q      <= '0;
            db_cnt_q    <= '0;
            sw_q        <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            irq_q       <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            led_q       <= '0;
            sel_q       <= '0;
            idle_q      <= '0;
            tx_q        <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            db_cnt_q    <= db_cnt_d;
            sw_q        <= sw_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            irq_q       <= irq_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            sel_q       <= sel_d;
            idle_q      <= idle_d;
            tx_q        <= tx_d;
        end
    end

    assign o_sw           = sw_q;
    assign o_sw_rise      = rise_q;
    assign o_sw_fall      = fall_q;
    assign o_irq          = irq_q;
    assign o_led          = led_q;
    assign uart.o_uart_sel = sel_q;
    assign uart.o_uart_tx  = tx_q;
endmodule

// File: doc/swervolf_board_io.md
# swervolf_board_io

Parametrised board I/O conditioning block between the SweRVolf core GPIO/UART pins and the physical board pins. Replaces the fixed two-flop switch synchroniser, LED pipeline and switch-driven UART TX mux in the Nexys top level with one reusable block. Adds:
- per-switch debounce;
- edge detection with a sticky interrupt;
- per-LED blink mode;
- an N-channel UART TX mux that changes source only when the line is idle.

## Interface
Parameters:
- SW_W, 16, number of switch inputs.
- LED_W, 16, number of LED outputs.
- SYNC_STAGES, 2, synchroniser depth (≥2).
- DEBOUNCE_CYCLES, 50000, stability window in clk cycles (≥1).
- BLINK_DIV, 12500000, clk cycles per blink half-period (≥1).
- UART_CH, 2, UART TX sources (≥2); SEL_W = $clog2(UART_CH).
- UART_IDLE, 16, consecutive idle-high cycles required before a source switch (≥1).

Ports:
- clk  in  1  core clock; sole clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- i_sw  in  SW_W  raw asynchronous switch pins.
- o_sw  out  SW_W  debounced switch state.
- o_sw_rise  out  SW_W  one-cycle pulse on a debounced 0→1 change.
- o_sw_fall  out  SW_W  one-cycle pulse on a debounced 1→0 change.
- i_irq_en  in  SW_W  per-bit edge interrupt enable.
- i_irq_clr  in  1  clears o_irq.
- o_irq  out  1  sticky edge interrupt.
- i_led  in  LED_W  LED values from GPIO.
- i_led_blink  in  LED_W  per-LED blink enable.
- o_led  out  LED_W  registered LED pins.
- i_uart_tx  in  UART_CH  TX lines from the candidate sources.
- i_uart_sel  in  SEL_W  requested source index.
- o_uart_sel  out  SEL_W  currently active source index.
- o_uart_tx  out  1  registered muxed TX pin.

## Operation
- Reset values (rstn low, asynchronous):
  - sync chain, stable state, debounce counters, o_sw, o_sw_rise, o_sw_fall, o_irq, o_led: all 0.
  - Blink phase 0; blink counter 0.
  - o_uart_sel = 0; idle counter 0.
  - o_uart_tx = 1 (line idle).
- Synchroniser: each i_sw bit passes through a SYNC_STAGES flop chain; s = last stage.
- Debounce, per bit:
  - If s == o_sw, the counter clears.
  - Otherwise the counter increments.
  - When s != o_sw and the counter == DEBOUNCE_CYCLES-1: o_sw <= s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches o_sw.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter must not wrap.
- Edges: o_sw_rise/o_sw_fall are registered on the same edge that o_sw updates and are high for exactly one cycle.
- IRQ:
  - o_irq sets when any bit of (o_sw_rise|o_sw_fall) & i_irq_en is high.
  - i_irq_clr clears o_irq.
  - A set and a clear in the same cycle resolve to set.
- Blink:
  - The counter runs 0..BLINK_DIV-1. On wrap, phase toggles.
  - o_led[i] <= i_led[i] & (~i_led_blink[i] | phase).
- UART mux:
  - o_uart_tx <= i_uart_tx[o_uart_sel].
  - Pending condition: i_uart_sel != o_uart_sel and i_uart_sel < UART_CH.
  - While pending, the idle counter increments each cycle that i_uart_tx[o_uart_sel] is 1.
  - The idle counter clears whenever that line is 0 or nothing is pending.
  - When the counter reaches UART_IDLE-1 with the line still high, o_uart_sel <= i_uart_sel and the counter clears.
  - An out-of-range select is ignored.
  - If i_uart_sel returns to o_uart_sel mid-wait, the switch is cancelled.

## Timing
- Switch latency: a raw change held stable appears on o_sw exactly SYNC_STAGES + DEBOUNCE_CYCLES clk edges after the first sampling edge.
- o_irq rises 1 cycle after the edge pulse.
- LED latency: 1 cycle from i_led/i_led_blink to o_led. Phase changes take effect on the edge after the toggle.
- UART data latency: 1 cycle.
- UART source switch: takes effect UART_IDLE cycles after the first qualifying idle cycle. The new source appears on o_uart_tx one cycle after o_uart_sel updates.
- A mid-frame request never cuts a frame unless the active line holds high for UART_IDLE cycles. UART_IDLE ≥ 10 bit times guarantees frame integrity.
- Reset mid-debounce or mid-switch: all state returns to reset values immediately. No pending switch survives reset.

## Test plan
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, BLINK_DIV=3, UART_CH=3, UART_IDLE=5.
- Debounce: hold i_sw[3] 0→1 → o_sw[3]=1 and a one-cycle o_sw_rise[3] at edge 6; a 3-cycle pulse on i_sw[5] → o_sw[5] stays 0 with no pulses.
- IRQ: set i_irq_en=0x0008, hold i_sw[3] low → o_irq=1. Assert i_irq_clr coincident with a second enabled edge → o_irq stays 1. A lone i_irq_clr → o_irq=0. An edge on a disabled bit → o_irq stays 0.
- Blink: i_led=0x0003, i_led_blink=0x0002 → o_led[0] constant 1; o_led[1] toggles every 3 cycles starting at 0.
- UART idle switch: source 0 low, i_uart_sel=2 → o_uart_sel stays 0. Source 0 goes high 5 cycles → o_uart_sel=2. o_uart_tx follows i_uart_tx[2] one cycle later.
- UART cancel and ignore: request 1, return i_uart_sel to 0 after 3 idle cycles → no switch. i_uart_sel=3 (out of range) → no switch.
- Reset: assert rstn low mid-debounce and mid-switch → o_uart_tx=1, o_uart_sel=0, o_led=0, o_sw=0, o_irq=0 immediately, without waiting for a clk edge.
